// File: rtl/c17_bist_ctrl.sv
// BIST controller for 5-input/2-output CUTs such as c17: an LFSR drives one pattern per cycle,
// a MISR compacts the responses, and the final signature is compared against a golden value.
module c17_bist_ctrl #(
    parameter int unsigned PAT_COUNT = 31,
    parameter logic [4:0]  SEED      = 5'b00001,
    parameter logic [7:0]  GOLDEN    = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cut_out,
    output logic [4:0] cut_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    if (PAT_COUNT < 1 || PAT_COUNT > 255) begin : g_bad_pat_count
        $error("PAT_COUNT must be in 1..255");
    end

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [4:0] SeedEff = (SEED == 5'd0) ? 5'd1 : SEED;
    localparam logic [7:0] LastCnt = 8'(PAT_COUNT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCmp
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] lfsr_q, lfsr_d;
    logic [7:0] misr_q, misr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    lfsr_d  = SeedEff;
                    misr_d  = 8'h00;
                    cnt_d   = 8'h00;
                    pass_d  = 1'b0;
                end
            end
            StRun: begin
                misr_d = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]}
                         ^ {6'b0, cut_out};
                lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[1]};
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q == LastCnt) begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
                state_d = StIdle;
                pass_d  = (misr_q == GOLDEN);
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            lfsr_q  <= 5'd0;
            misr_q  <= 8'h00;
            cnt_q   <= 8'h00;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign cut_in    = (state_q == StIdle) ? 5'd0 : lfsr_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Bench for c17_bist_ctrl: several instances with different parameters, a timeline model
// checked every cycle, and directed runs with hand-computed expectations.
module tb_c17_bist_ctrl;

    localparam int NI = 6;

    function automatic logic [1:0] c17(input logic [4:0] x, input logic sa0_g16);
        logic g10, g11, g16, g19, g22, g23;
        g10 = ~(x[0] & x[2]);
        g11 = ~(x[2] & x[3]);
        g16 = ~(x[1] & g11);
        if (sa0_g16) g16 = 1'b0;
        g19 = ~(g11 & x[4]);
        g22 = ~(g10 & g16);
        g23 = ~(g16 & g19);
        return {g23, g22};
    endfunction

    // Pattern number n of a run started from seed.
    function automatic logic [4:0] lfsr_n(input logic [4:0] seed, input int n);
        logic [4:0] l;
        l = (seed == 5'd0) ? 5'd1 : seed;
        for (int i = 0; i < n; i++) l = {l[3:0], l[4] ^ l[1]};
        return l;
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [1:0] r);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {6'b0, r};
    endfunction

    function automatic logic [7:0] golden(input int p, input logic [4:0] seed);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < p; i++) s = misr_step(s, c17(lfsr_n(seed, i), 1'b0));
        return s;
    endfunction

    function automatic int pc_of(input int g);
        case (g)
            0: return 31;
            1, 2: return 3;
            3, 4: return 1;
            default: return 40;
        endcase
    endfunction

    function automatic logic [4:0] sd_of(input int g);
        case (g)
            4: return 5'd0;
            5: return 5'h13;
            default: return 5'd1;
        endcase
    endfunction

    function automatic logic [7:0] gd_of(input int g);
        case (g)
            0: return golden(31, 5'd1);
            1: return 8'h07;
            2: return 8'h06;
            default: return 8'h00;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst;
    logic          fault;
    logic [NI-1:0] start;
    logic [1:0]    cut_out_w [NI];
    logic [4:0]    cut_in_w  [NI];
    logic          busy_w    [NI];
    logic          done_w    [NI];
    logic          pass_w    [NI];
    logic [7:0]    sig_w     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        // Instances 1 and 2 see a constant response; the rest see a c17 NAND network.
        assign cut_out_w[g] = (g == 1 || g == 2) ? 2'b01 : c17(cut_in_w[g], fault && (g == 0));
        c17_bist_ctrl #(
            .PAT_COUNT(pc_of(g)),
            .SEED     (sd_of(g)),
            .GOLDEN   (gd_of(g))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start[g]),
            .cut_out  (cut_out_w[g]),
            .cut_in   (cut_in_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .pass     (pass_w[g]),
            .signature(sig_w[g])
        );
    end

    // Model: m_t counts edges since the accepting edge; RUN/CMP while m_t <= P, done at P+1.
    bit       m_act  [NI];
    int       m_t    [NI];
    bit [7:0] m_sig  [NI];
    bit       m_pass [NI];

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                m_act[g]  <= 1'b0;
                m_t[g]    <= 0;
                m_sig[g]  <= 8'h00;
                m_pass[g] <= 1'b0;
            end else if ((!m_act[g] || m_t[g] >= pc_of(g) + 1) && start[g]) begin
                m_act[g]  <= 1'b1;
                m_t[g]    <= 0;
                m_sig[g]  <= 8'h00;
                m_pass[g] <= 1'b0;
            end else if (m_act[g]) begin
                if (m_t[g] < pc_of(g)) begin
                    m_sig[g] <= misr_step(m_sig[g], (g == 1 || g == 2) ? 2'b01 :
                                          c17(lfsr_n(sd_of(g), m_t[g]), fault && (g == 0)));
                end
                if (m_t[g] == pc_of(g)) m_pass[g] <= (m_sig[g] == gd_of(g));
                if (m_t[g] <= pc_of(g) + 1) m_t[g] <= m_t[g] + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    logic [4:0] hist_ci  [64];
    logic [7:0] hist_sig [64];

    task automatic chk(input string name, input int g, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst %0d: got %h, expected %h", name, g, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < NI; g++) begin
            bit         run_e;
            logic [4:0] ci_e;
            run_e = m_act[g] && (m_t[g] <= pc_of(g));
            ci_e  = run_e ? lfsr_n(sd_of(g), m_t[g]) : 5'd0;
            chk("cut_in", g, 8'(cut_in_w[g]), 8'(ci_e));
            chk("busy", g, 8'(busy_w[g]), 8'(run_e));
            chk("done", g, 8'(done_w[g]), 8'(m_act[g] && m_t[g] == pc_of(g) + 1));
            chk("pass", g, 8'(pass_w[g]), 8'(m_pass[g]));
            chk("signature", g, sig_w[g], m_sig[g]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic zero_outputs(input int g);
        chk("rst cut_in", g, 8'(cut_in_w[g]), 8'h00);
        chk("rst busy", g, 8'(busy_w[g]), 8'h00);
        chk("rst done", g, 8'(done_w[g]), 8'h00);
        chk("rst pass", g, 8'(pass_w[g]), 8'h00);
        chk("rst signature", g, sig_w[g], 8'h00);
    endtask

    // Pulse start and return the number of cycles until done is seen (0 on timeout).
    task automatic run(input int g, output int lat);
        lat = 0;
        start[g] = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            start[g] = 1'b0;
            hist_ci[n]  = cut_in_w[g];
            hist_sig[n] = sig_w[g];
            if (done_w[g]) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            errors++;
            $display("FAIL done timeout inst %0d: got no done, expected one within 60 cycles", g);
        end
    endtask

    initial begin
        int         lat;
        int         ndone;
        logic [4:0] exp_seq [6];
        exp_seq = '{5'h01, 5'h02, 5'h05, 5'h0A, 5'h15, 5'h0B};
        rst   = 1'b1;
        start = '0;
        fault = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        zero_outputs(0);
        rst = 1'b0;
        tick();

        // LFSR sequence and real c17 golden signature
        run(0, lat);
        chk("latency P=31", 0, 8'(lat), 8'd33);
        for (int i = 0; i < 6; i++) chk("lfsr seq", 0, 8'(hist_ci[i+1]), 8'(exp_seq[i]));
        chk("lfsr wrap", 0, 8'(hist_ci[32]), 8'h01);
        chk("c17 signature", 0, sig_w[0], golden(31, 5'd1));
        chk("c17 pass", 0, 8'(pass_w[0]), 8'h01);

        // Stuck-at-0 on G16
        fault = 1'b1;
        tick();
        run(0, lat);
        chk("fault pass", 0, 8'(pass_w[0]), 8'h00);
        fault = 1'b0;
        tick();

        // MISR arithmetic with a constant response
        run(1, lat);
        chk("latency P=3", 1, 8'(lat), 8'd5);
        chk("misr step1", 1, hist_sig[2], 8'h01);
        chk("misr step2", 1, hist_sig[3], 8'h03);
        chk("misr step3", 1, hist_sig[4], 8'h07);
        chk("golden 07 pass", 1, 8'(pass_w[1]), 8'h01);
        run(2, lat);
        chk("golden 06 pass", 2, 8'(pass_w[2]), 8'h00);
        chk("golden 06 sig", 2, sig_w[2], 8'h07);

        // start held for 40 edges: back-to-back runs of 5 cycles each
        ndone = 0;
        start[1] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (c == 39) start[1] = 1'b0;
            if (done_w[1]) ndone++;
        end
        chk("back-to-back dones", 1, 8'(ndone), 8'd8);

        // Reset at pattern 10, then a clean run
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (10) tick();
        chk("pattern 10", 0, 8'(cut_in_w[0]), 8'(lfsr_n(5'd1, 10)));
        #1 rst = 1'b1;
        #1 zero_outputs(0);
        tick();
        rst = 1'b0;
        tick();
        run(0, lat);
        chk("latency after rst", 0, 8'(lat), 8'd33);
        chk("pass after rst", 0, 8'(pass_w[0]), 8'h01);

        // PAT_COUNT=1 with SEED=1 and SEED=0
        run(3, lat);
        chk("latency P=1", 3, 8'(lat), 8'd3);
        chk("sig P=1", 3, sig_w[3], 8'h00);
        chk("pass P=1", 3, 8'(pass_w[3]), 8'h01);
        run(4, lat);
        chk("latency seed0", 4, 8'(lat), 8'd3);
        chk("pattern seed0", 4, 8'(hist_ci[1]), 8'h01);
        chk("sig seed0", 4, sig_w[4], 8'h00);

        // PAT_COUNT=40 wraps the LFSR period
        run(5, lat);
        chk("latency P=40", 5, 8'(lat), 8'd42);
        chk("seed 13", 5, 8'(hist_ci[1]), 8'h13);
        chk("wrap 31", 5, 8'(hist_ci[32]), 8'h13);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
